ram_sdp_be_param: RTL and testbench

//  Single-clock simple-dual-port RAM: one write port with byte-lane enables, one read port.

---
 rtl/ram_sdp_be_param.sv | 144 ++++++++++++++
 tb/tb_ram_sdp_be_param.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_sdp_be_param.sv
// ram_sdp_be_param
//   Single-clock simple-dual-port RAM with byte-lane write enables. Serves as
//   the generic line/block buffer for the JPEG encoder pipeline.
//
//   Features: read-valid strobe, per-lane write-first collision forwarding,
//   held read data, out-of-range address protection, optional output stage.
//
//   Build option:
//     RAM_SDP_OUTREG_EN  defined   -> extra output register, read latency 2
//                        undefined -> read latency 1
//
//   Ports:
//     clk_i       single clock
//     resetn_i    asynchronous active-low reset (array contents not reset)
//     wr_en_i     write request
//     ben_i       lane enables, bit k gates wr_data_i[k*BW +: BW]
//     wr_addr_i   write address
//     wr_data_i   write data
//     rd_en_i     read request
//     rd_addr_i   read address
//     rd_data_o   read data, held until the next accepted read
//     rd_valid_o  one-cycle strobe, rd_data_o is new this cycle
module ram_sdp_be_param #(
    parameter int DW    = 32,
    parameter int BW    = 8,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH),
    parameter int NB    = DW / BW
) (
    input  logic          clk_i,
    input  logic          resetn_i,
    input  logic          wr_en_i,
    input  logic [NB-1:0] ben_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o,
    output logic          rd_valid_o
);

    if ((DW % BW) != 0 || DEPTH < 2) begin : g_param_check
        $error("ram_sdp_be_param: DW must be a multiple of BW and DEPTH must be >= 2");
    end

    logic [DW-1:0] mem [DEPTH];

    logic          wr_in_range;
    logic          rd_in_range;
    logic          collide;

    logic [DW-1:0] mem_q;
    logic          req_q;
    logic          oor_q;
    logic [NB-1:0] fwd_mask_q;
    logic [DW-1:0] fwd_data_q;
    logic [DW-1:0] merged;

    // DEPTH need not be a power of two, so the address space can exceed it.
    assign wr_in_range = 32'(wr_addr_i) < 32'(DEPTH);
    assign rd_in_range = 32'(rd_addr_i) < 32'(DEPTH);
    assign collide     = wr_en_i && rd_en_i && wr_in_range && rd_in_range
                         && (wr_addr_i == rd_addr_i);

    // Behavioural byte-enable array, kept free of reset so it maps to EBR.
    always_ff @(posedge clk_i) begin
        if (wr_en_i && wr_in_range) begin
            for (int k = 0; k < NB; k++) begin
                if (ben_i[k]) begin
                    mem[wr_addr_i][k*BW +: BW] <= wr_data_i[k*BW +: BW];
                end
            end
        end
    end

    // Synchronous read returns the pre-write word; collisions are patched
    // afterwards from the registered forward mask/data.
    always_ff @(posedge clk_i) begin
        if (rd_en_i && rd_in_range) begin
            mem_q <= mem[rd_addr_i];
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            req_q      <= 1'b0;
            oor_q      <= 1'b0;
            fwd_mask_q <= '0;
            fwd_data_q <= '0;
        end else begin
            req_q      <= rd_en_i;
            oor_q      <= ~rd_in_range;
            fwd_mask_q <= collide ? ben_i : '0;
            fwd_data_q <= wr_data_i;
        end
    end

    always_comb begin
        merged = '0;
        if (!oor_q) begin
            for (int k = 0; k < NB; k++) begin
                merged[k*BW +: BW] = fwd_mask_q[k] ? fwd_data_q[k*BW +: BW]
                                                   : mem_q[k*BW +: BW];
            end
        end
    end

`ifdef RAM_SDP_OUTREG_EN
    logic [DW-1:0] out_q;
    logic          out_valid_q;

    // The output register doubles as the hold register.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= req_q;
            if (req_q) begin
                out_q <= merged;
            end
        end
    end

    assign rd_data_o  = out_q;
    assign rd_valid_o = out_valid_q;
`else
    logic [DW-1:0] hold_q;

    // New data goes straight out in the valid cycle and is captured so it
    // can be presented until the next accepted read.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            hold_q <= '0;
        end else if (req_q) begin
            hold_q <= merged;
        end
    end

    assign rd_data_o  = req_q ? merged : hold_q;
    assign rd_valid_o = req_q;
`endif

endmodule

// File: tb/tb_ram_sdp_be_param.sv
module tb_ram_sdp_be_param;

`ifdef RAM_SDP_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk     = 1'b0;
    logic        resetn  = 1'b1;
    logic        wr_en   = 1'b0;
    logic [3:0]  ben     = '0;
    logic [5:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        rd_en   = 1'b0;
    logic [5:0]  rd_addr = '0;

    logic [31:0] rd_data64, rd_data48;
    logic        rd_valid64, rd_valid48;

    ram_sdp_be_param #(.DW(32), .BW(8), .DEPTH(64)) u_dut (
        .clk_i      (clk),
        .resetn_i   (resetn),
        .wr_en_i    (wr_en),
        .ben_i      (ben),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .rd_en_i    (rd_en),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data64),
        .rd_valid_o (rd_valid64)
    );

    ram_sdp_be_param #(.DW(32), .BW(8), .DEPTH(48)) u_dut48 (
        .clk_i      (clk),
        .resetn_i   (resetn),
        .wr_en_i    (wr_en),
        .ben_i      (ben),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .rd_en_i    (rd_en),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data48),
        .rd_valid_o (rd_valid48)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] due;
    } exp_t;

    exp_t        exp_q [2][$];
    logic [31:0] mdl   [2][64];
    logic [31:0] last  [2];
    int          dep   [2];

    initial begin
        dep[0]  = 64;
        dep[1]  = 48;
        last[0] = '0;
        last[1] = '0;
    end

    // One cycle of stimulus; expected read results are derived from the
    // reference model before the model absorbs this cycle's write.
    task automatic op(input logic we, input logic [3:0] be, input logic [5:0] wa,
                      input logic [31:0] wd, input logic re, input logic [5:0] ra);
        exp_t        e;
        logic [31:0] d;
        @(posedge clk);
        #1;
        wr_en   = we;
        ben     = be;
        wr_addr = wa;
        wr_data = wd;
        rd_en   = re;
        rd_addr = ra;
        for (int p = 0; p < 2; p++) begin
            if (re) begin
                d = '0;
                if (int'(ra) < dep[p]) begin
                    for (int k = 0; k < 4; k++) begin
                        if (we && int'(wa) < dep[p] && wa == ra && be[k])
                            d[k*8 +: 8] = wd[k*8 +: 8];
                        else
                            d[k*8 +: 8] = mdl[p][ra][k*8 +: 8];
                    end
                end
                e.data = d;
                e.due  = 32'(cyc + LAT);
                exp_q[p].push_back(e);
            end
            if (we && int'(wa) < dep[p]) begin
                for (int k = 0; k < 4; k++) begin
                    if (be[k]) mdl[p][wa][k*8 +: 8] = wd[k*8 +: 8];
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(1'b0, 4'h0, 6'd0, 32'h0, 1'b0, 6'd0);
    endtask

    task automatic mon(input int p, input logic v, input logic [31:0] d);
        exp_t  e;
        string nm;
        nm = (p == 0) ? "d64" : "d48";
        if (v === 1'b1) begin
            if (exp_q[p].size() == 0) begin
                check_val({nm, "_stale_strobe"}, 32'(exp_q[p].size()), 32'd1);
            end else begin
                e = exp_q[p].pop_front();
                check_val({nm, "_rd_data"}, d, e.data);
                check_val({nm, "_latency"}, 32'(cyc), e.due);
                last[p] = e.data;
            end
        end else begin
            check_val({nm, "_hold"}, d, last[p]);
            if (exp_q[p].size() != 0 && int'(exp_q[p][0].due) <= cyc) begin
                check_val({nm, "_valid_missing"}, {31'b0, v}, 32'd1);
                void'(exp_q[p].pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, rd_valid64, rd_data64);
        mon(1, rd_valid48, rd_data48);
    end

    task automatic assert_reset();
        resetn = 1'b0;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        ben    = '0;
        exp_q[0].delete();
        exp_q[1].delete();
        last[0] = '0;
        last[1] = '0;
        #1;
        check_val("rst_valid64", {31'b0, rd_valid64}, 32'd0);
        check_val("rst_valid48", {31'b0, rd_valid48}, 32'd0);
        check_val("rst_data64", rd_data64, 32'd0);
        check_val("rst_data48", rd_data48, 32'd0);
    endtask

    initial begin
        #1;
        assert_reset();
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        // 1: full-word write then read
        op(1'b1, 4'hF, 6'd5, 32'hDEADBEEF, 1'b0, 6'd0);
        op(1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 6'd5);
        idle(LAT + 1);
        check_val("s1_hold", rd_data64, 32'hDEADBEEF);

        // 2: partial-lane write
        op(1'b1, 4'hF, 6'd7, 32'h11223344, 1'b0, 6'd0);
        op(1'b1, 4'b0101, 6'd7, 32'hAABBCCDD, 1'b0, 6'd0);
        op(1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 6'd7);
        idle(LAT + 1);
        check_val("s2_merge", rd_data64, 32'h11BB33DD);

        // ben=0 write is a no-op
        op(1'b1, 4'h0, 6'd7, 32'h0, 1'b0, 6'd0);
        op(1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 6'd7);

        // 3: same-cycle collision, per-lane write-first, then re-read
        op(1'b1, 4'hF, 6'd3, 32'h01234567, 1'b0, 6'd0);
        op(1'b1, 4'b1100, 6'd3, 32'hCAFE0000, 1'b1, 6'd3);
        idle(LAT + 1);
        check_val("s3_collide", rd_data64, 32'hCAFE4567);
        op(1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 6'd3);
        // collision on a different address must not forward
        op(1'b1, 4'hF, 6'd4, 32'h55555555, 1'b1, 6'd3);

        // 4: fill and stream back
        for (int a = 0; a < 64; a++)
            op(1'b1, 4'hF, 6'(a), 32'(a) * 32'h01010101, 1'b0, 6'd0);
        for (int a = 0; a < 64; a++)
            op(1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 6'(a));
        idle(LAT + 2);
        check_val("s4_hold64", rd_data64, 32'h3F3F3F3F);
        check_val("s4_hold48", rd_data48, 32'h0);

        // 5: out-of-range on DEPTH=48
        op(1'b1, 4'hF, 6'd50, 32'hFFFFFFFF, 1'b0, 6'd0);
        op(1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 6'd50);
        idle(LAT + 1);
        check_val("s5_oor48", rd_data48, 32'h0);
        op(1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 6'd47);
        idle(LAT + 1);
        check_val("s5_keep47", rd_data48, 32'h2F2F2F2F);
        op(1'b1, 4'hF, 6'd50, 32'h12345678, 1'b1, 6'd50);
        idle(LAT + 1);

        // 6: reset with reads in flight
        op(1'b1, 4'hF, 6'd5, 32'hDEADBEEF, 1'b0, 6'd0);
        op(1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 6'd5);
        op(1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 6'd7);
        op(1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 6'd3);
        @(posedge clk);
        #1;
        assert_reset();
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        idle(LAT + 3);
        op(1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 6'd5);
        idle(LAT + 2);
        check_val("s6_retained", rd_data64, 32'hDEADBEEF);

        check_val("q64_drained", 32'(exp_q[0].size()), 32'd0);
        check_val("q48_drained", 32'(exp_q[1].size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
